// File: rtl/sequenciador_decodificador_if.sv
// Handshake and decoder-side signals of the character-decoder sequencer.
// The slave modport is the sequencer view; the master modport is the environment view.
interface sequenciador_decodificador_if;
  logic       req0_valid;
  logic [6:0] req0_char;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [6:0] req1_char;
  logic       req1_last;
  logic       req1_ready;
  logic [6:0] dec_Entrada;
  logic       dec_Controle;
  logic       dec_Reset;
  logic [3:0] dec_Saida;
  logic       res_valid;
  logic       res_id;
  logic [1:0] res_code;
  logic       res_ready;
  logic       busy;

  modport slave (
    input  req0_valid, req0_char, req0_last,
    output req0_ready,
    input  req1_valid, req1_char, req1_last,
    output req1_ready,
    output dec_Entrada, dec_Controle, dec_Reset,
    input  dec_Saida,
    output res_valid, res_id, res_code,
    input  res_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_char, req0_last,
    input  req0_ready,
    output req1_valid, req1_char, req1_last,
    input  req1_ready,
    input  dec_Entrada, dec_Controle, dec_Reset,
    output dec_Saida,
    input  res_valid, res_id, res_code,
    output res_ready,
    input  busy
  );
endinterface

// File: rtl/sequenciador_decodificador.sv
// Round-robin scheduler in front of the 7-bit character decoder: clears it, presents one
// character at a time for HOLD_CYC cycles, samples Saida and reports one result code per word.
module sequenciador_decodificador #(
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned CLR_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [3:0]  COD_SAIDA1  = 4'd6,
  parameter logic [3:0]  COD_SAIDA2  = 4'd7,
  parameter logic [3:0]  COD_INVAL   = 4'd15
) (
  input logic                         clk,
  input logic                         Reset,
  sequenciador_decodificador_if.slave bus
);

  localparam int unsigned MAX_HC  = (HOLD_CYC > CLR_CYC) ? HOLD_CYC : CLR_CYC;
  localparam int unsigned MAX_CYC = (TIMEOUT_CYC > MAX_HC) ? TIMEOUT_CYC : MAX_HC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] CLR_END  = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TO_END   = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0]    RC_INCOMPLETO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LIMPA     = 3'd1,
    S_ESPERA    = 3'd2,
    S_APRESENTA = 3'd3,
    S_AVALIA    = 3'd4,
    S_DESCARTA  = 3'd5,
    S_RESULTADO = 3'd6
  } state_e;

  // Returns {terminal, code} for a decoder Saida value.
  function automatic logic [2:0] classify(input logic [3:0] saida);
    logic [2:0] r;
    if (saida == COD_SAIDA1) begin
      r = {1'b1, 2'd0};
    end else if (saida == COD_SAIDA2) begin
      r = {1'b1, 2'd1};
    end else if (saida == COD_INVAL) begin
      r = {1'b1, 2'd2};
    end else begin
      r = {1'b0, RC_INCOMPLETO};
    end
    return r;
  endfunction

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    char_q, char_d;
  logic          last_q, last_d;
  logic [1:0]    code_q, code_d;

  logic          window_s;
  logic          own_valid_s;
  logic [6:0]    own_char_s;
  logic          own_last_s;
  logic          accept_s;
  logic [2:0]    verdict_s;

  assign window_s    = (state_q == S_ESPERA) || (state_q == S_DESCARTA);
  assign own_valid_s = owner_q ? bus.req1_valid : bus.req0_valid;
  assign own_char_s  = owner_q ? bus.req1_char  : bus.req0_char;
  assign own_last_s  = owner_q ? bus.req1_last  : bus.req0_last;
  assign accept_s    = window_s && own_valid_s;
  assign verdict_s   = classify(bus.dec_Saida);

  assign bus.req0_ready   = window_s && !owner_q;
  assign bus.req1_ready   = window_s && owner_q;
  assign bus.dec_Entrada  = char_q;
  assign bus.dec_Controle = (state_q == S_APRESENTA);
  assign bus.dec_Reset    = (state_q == S_IDLE) || (state_q == S_LIMPA);
  assign bus.res_valid    = (state_q == S_RESULTADO);
  assign bus.res_id       = owner_q;
  assign bus.res_code     = code_q;
  assign bus.busy         = (state_q != S_IDLE);

  // State and datapath registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      char_q  <= 7'd0;
      last_q  <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      last_q  <= last_d;
      code_q  <= code_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    last_d  = last_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req0_valid || bus.req1_valid) begin
          // The pointed-to requester wins only if it is actually asking.
          if (rr_q) begin
            owner_d = bus.req1_valid ? 1'b1 : 1'b0;
          end else begin
            owner_d = bus.req0_valid ? 1'b0 : 1'b1;
          end
          state_d = S_LIMPA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LIMPA: begin
        if (cnt_q == CLR_END) begin
          cnt_d   = '0;
          state_d = S_ESPERA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ESPERA: begin
        if (accept_s) begin
          char_d  = own_char_s;
          last_d  = own_last_s;
          cnt_d   = '0;
          state_d = S_APRESENTA;
        end else if (cnt_q == TO_END) begin
          cnt_d   = '0;
          code_d  = RC_INCOMPLETO;
          state_d = S_RESULTADO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_APRESENTA: begin
        if (cnt_q == HOLD_END) begin
          cnt_d   = '0;
          state_d = S_AVALIA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_AVALIA: begin
        cnt_d = '0;
        if (verdict_s[2]) begin
          code_d  = verdict_s[1:0];
          state_d = last_q ? S_RESULTADO : S_DESCARTA;
        end else if (last_q) begin
          code_d  = RC_INCOMPLETO;
          state_d = S_RESULTADO;
        end else begin
          state_d = S_ESPERA;
        end
      end
      S_DESCARTA: begin
        // Remaining characters are drained without touching the decoder; the terminal code stays.
        if (accept_s) begin
          cnt_d   = '0;
          state_d = own_last_s ? S_RESULTADO : S_DESCARTA;
        end else if (cnt_q == TO_END) begin
          cnt_d   = '0;
          state_d = S_RESULTADO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESULTADO: begin
        if (bus.res_ready) begin
          rr_d    = ~owner_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_RESULTADO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sequenciador_decodificador.sv
// Scoreboard bench for sequenciador_decodificador with a behavioural decoder and word-level model.
module tb_sequenciador_decodificador;
  localparam int HOLD = 4;
  localparam int CLR  = 2;
  localparam int TO   = 64;

  logic clk;
  logic rst_n;

  sequenciador_decodificador_if bus();

  sequenciador_decodificador #(
    .HOLD_CYC(HOLD), .CLR_CYC(CLR), .TIMEOUT_CYC(TO),
    .COD_SAIDA1(4'd6), .COD_SAIDA2(4'd7), .COD_INVAL(4'd15)
  ) u_dut (
    .clk(clk),
    .Reset(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] w0_q[$];
  logic [7:0] w1_q[$];
  logic [2:0] exp_q[$];
  logic [6:0] pres_q[$];
  logic [6:0] wbuf[8];
  logic [6:0] sym[7];
  int         rdy_mode = 0;
  logic [3:0] dsaida = 4'd0;
  logic       ctl_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Decoder behaviour: one transition per presentation, terminal states absorb.
  function automatic logic [3:0] dnext(input logic [3:0] s, input logic [6:0] c);
    if (s == 4'd6 || s == 4'd7 || s == 4'd15) return s;
    if (s == 4'd0 && c == 7'd1) return 4'd1;
    if (s == 4'd0 && c == 7'd4) return 4'd4;
    if (s == 4'd1 && c == 7'd6) return 4'd6;
    if (s == 4'd1 && c == 7'd7) return 4'd15;
    if (s == 4'd1 && c == 7'd2) return 4'd2;
    if (s == 4'd2 && c == 7'd3) return 4'd3;
    if (s == 4'd2 && c == 7'd8) return 4'd15;
    if (s == 4'd3 && c == 7'd7) return 4'd7;
    if (s == 4'd4 && c == 7'd8) return 4'd7;
    if (s == 4'd5 && c == 7'd6) return 4'd6;
    return 4'd5;
  endfunction

  always @(posedge clk) begin
    if (bus.dec_Reset) dsaida <= 4'd0;
    else if (bus.dec_Controle && !ctl_d) dsaida <= dnext(dsaida, bus.dec_Entrada);
    ctl_d <= bus.dec_Controle;
  end
  assign bus.dec_Saida = dsaida;

  // Queue a word for requester id; the model predicts presented characters and result code.
  task automatic add_word(input int id, input int len, input bit send_last);
    logic [3:0] s;
    logic [1:0] code;
    bit         done;
    logic [7:0] e;
    s = 4'd0; code = 2'd3; done = 1'b0;
    for (int i = 0; i < len; i++) begin
      e = {(send_last && i == len - 1), wbuf[i]};
      if (id == 0) w0_q.push_back(e);
      else w1_q.push_back(e);
      if (!done) begin
        pres_q.push_back(wbuf[i]);
        s = dnext(s, wbuf[i]);
        if (s == 4'd6)       begin done = 1'b1; code = 2'd0; end
        else if (s == 4'd7)  begin done = 1'b1; code = 2'd1; end
        else if (s == 4'd15) begin done = 1'b1; code = 2'd2; end
      end
    end
    exp_q.push_back({id[0], code});
  endtask

  task automatic at_mid();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (k < budget && (exp_q.size() != 0 || w0_q.size() != 0 || w1_q.size() != 0 || bus.busy)) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic set2(input logic [6:0] a, input logic [6:0] b);
    wbuf[0] = a; wbuf[1] = b;
  endtask

  // Requester 0 driver.
  initial begin
    bus.req0_valid = 1'b0; bus.req0_char = 7'd0; bus.req0_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && w0_q.size() > 0) begin
        bus.req0_valid = 1'b1; bus.req0_char = w0_q[0][6:0]; bus.req0_last = w0_q[0][7];
        if (bus.req0_ready) begin
          @(posedge clk); #1;
          void'(w0_q.pop_front());
          bus.req0_valid = 1'b0;
        end
      end else begin
        bus.req0_valid = 1'b0;
      end
    end
  end

  // Requester 1 driver.
  initial begin
    bus.req1_valid = 1'b0; bus.req1_char = 7'd0; bus.req1_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && w1_q.size() > 0) begin
        bus.req1_valid = 1'b1; bus.req1_char = w1_q[0][6:0]; bus.req1_last = w1_q[0][7];
        if (bus.req1_ready) begin
          @(posedge clk); #1;
          void'(w1_q.pop_front());
          bus.req1_valid = 1'b0;
        end
      end else begin
        bus.req1_valid = 1'b0;
      end
    end
  end

  initial begin
    bus.res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.res_ready = 1'($urandom_range(0, 1));
        2:       bus.res_ready = 1'b0;
        default: bus.res_ready = 1'b1;
      endcase
    end
  end

  // Monitor: presentation checks and result scoreboard.
  initial begin
    int         run;
    logic       stalled;
    logic [2:0] held;
    logic [2:0] e;
    run = 0; stalled = 1'b0; held = 3'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0; stalled = 1'b0;
      end else begin
        if (bus.dec_Controle) begin
          if (run == 0) begin
            if (pres_q.size() == 0) chk("present_unexpected", pres_q.size(), 1);
            else chk("dec_Entrada", bus.dec_Entrada, pres_q.pop_front());
          end
          run++;
        end else if (run != 0) begin
          chk("controle_width", run, HOLD);
          run = 0;
        end
        if (bus.res_valid) begin
          if (stalled) chk("res_stable", {bus.res_id, bus.res_code}, held);
          if (bus.res_ready) begin
            if (exp_q.size() == 0) chk("res_unexpected", exp_q.size(), 1);
            else begin
              e = exp_q.pop_front();
              chk("res_id", bus.res_id, e[2]);
              chk("res_code", bus.res_code, e[1:0]);
            end
            stalled = 1'b0;
          end else begin
            stalled = 1'b1;
            held = {bus.res_id, bus.res_code};
          end
        end else begin
          if (stalled) chk("res_valid_dropped", bus.res_valid, 1);
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    int lat;
    int id;
    int len;
    sym[0] = 7'd1; sym[1] = 7'd2; sym[2] = 7'd3; sym[3] = 7'd4;
    sym[4] = 7'd6; sym[5] = 7'd7; sym[6] = 7'd8;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_code", bus.res_code, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    chk("rst_dec_Entrada", bus.dec_Entrada, 0);
    chk("rst_dec_Controle", bus.dec_Controle, 0);
    chk("rst_dec_Reset", bus.dec_Reset, 1);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;

    // Single-character word: busy cycles after the IDLE grant until res_valid.
    at_mid();
    wbuf[0] = 7'd1;
    add_word(0, 1, 1'b1);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.res_valid) break;
      if (bus.busy) lat++;
    end
    chk("latency_reached", bus.res_valid, 1);
    chk("latency", lat, CLR + 1 + HOLD + 1);
    wait_drain(200);

    at_mid(); set2(7'd1, 7'd6); add_word(0, 2, 1'b1); wait_drain(200);
    at_mid(); set2(7'd4, 7'd8); add_word(1, 2, 1'b1); wait_drain(200);
    at_mid(); set2(7'd1, 7'd7); add_word(1, 2, 1'b1); wait_drain(200);
    at_mid(); set2(7'd1, 7'd2); wbuf[2] = 7'd3; add_word(0, 3, 1'b1); wait_drain(200);
    at_mid(); wbuf[0] = 7'd1; add_word(0, 1, 1'b0); wait_drain(300);
    at_mid(); set2(7'd1, 7'd6); wbuf[2] = 7'd2; wbuf[3] = 7'd3; add_word(0, 4, 1'b1); wait_drain(300);

    // Arbitration from a fresh reset with both requesters pending.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    at_mid();
    set2(7'd1, 7'd6); add_word(0, 2, 1'b1);
    set2(7'd4, 7'd8); add_word(1, 2, 1'b1);
    set2(7'd1, 7'd7); add_word(0, 2, 1'b1);
    set2(7'd1, 7'd2); wbuf[2] = 7'd3; add_word(1, 3, 1'b1);
    wait_drain(800);

    // Reset during presentation aborts the word.
    at_mid(); set2(7'd1, 7'd6); add_word(0, 2, 1'b1);
    for (int i = 0; i < 50 && !bus.dec_Controle; i++) @(negedge clk);
    chk("abort_reached_present", bus.dec_Controle, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_dec_Controle", bus.dec_Controle, 0);
    chk("abort_dec_Entrada", bus.dec_Entrada, 0);
    chk("abort_dec_Reset", bus.dec_Reset, 1);
    chk("abort_res_valid", bus.res_valid, 0);
    chk("abort_req0_ready", bus.req0_ready, 0);
    w0_q.delete(); w1_q.delete(); exp_q.delete(); pres_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("abort_no_result", bus.res_valid, 0);
    end

    // Result held while the consumer stalls; a pending requester is not granted.
    rdy_mode = 2;
    at_mid(); set2(7'd1, 7'd6); add_word(0, 2, 1'b1);
    for (int i = 0; i < 50 && !bus.res_valid; i++) @(negedge clk);
    chk("stall_reached", bus.res_valid, 1);
    at_mid(); set2(7'd4, 7'd8); add_word(1, 2, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("stall_res_valid", bus.res_valid, 1);
      chk("stall_res_id", bus.res_id, 0);
      chk("stall_res_code", bus.res_code, 0);
      chk("stall_req1_ready", bus.req1_ready, 0);
      chk("stall_dec_Reset", bus.dec_Reset, 0);
    end
    rdy_mode = 0;
    wait_drain(300);

    // Randomised words with a randomly stalling consumer.
    rdy_mode = 1;
    for (int n = 0; n < 24; n++) begin
      id  = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 4));
      for (int j = 0; j < len; j++) wbuf[j] = sym[$urandom_range(0, 6)];
      at_mid();
      add_word(id, len, 1'b1);
      wait_drain(400);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
